matrix_mult_sequencer: RTL and testbench
========================================

Name: matrix_mult_sequencer

Overview:
- Execute-stage companion to the control decoder. Consumes the matrix-multiply flag on R-type funct 011.
- Takes two packed 2x2 matrices of DATA_W-bit elements and computes C = A x B, one element per cycle.
- Drives the four results into the register-file write port at consecutive destination registers.
- Stalls the pipeline for the whole operation so the single write port is never contended.

Parameters:
- DATA_W, 8, element width and register width.
- REG_AW, 3, register address width (8 registers); address arithmetic wraps modulo 2^REG_AW.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  matrix-mult instruction valid in EX (is_matrix_mult AND stage valid).
- abort  in  1  synchronous flush; cancels any operation in progress.
- a_mat  in  4*DATA_W  operand A; a00=[DW-1:0], a01=[2DW-1:DW], a10=[3DW-1:2DW], a11=[4DW-1:3DW].
- b_mat  in  4*DATA_W  operand B, same packing.
- rd_base  in  REG_AW  first destination register.
- stall  out  1  freeze PC, IF/ID and ID/EX.
- wr_en  out  1  register-file write enable (overrides pipeline writeback when high).
- wr_addr  out  REG_AW  write address.
- wr_data  out  DATA_W  write data.
- done  out  1  one-cycle pulse marking the final cycle of the operation.
- mm_ovf  out  1  at least one element exceeded 2^DATA_W-1 before truncation; valid while done=1.

Behaviour:
- States: IDLE, RUN, DONE. 2-bit element index idx. Latched operand copies A_q, B_q, base_q.
- Reset (asynchronous, any state): state=IDLE, idx=0, wr_en=0, wr_addr=0, wr_data=0, mm_ovf=0. done=0 and stall=0 as a result. Any operation in progress is dropped and no further writes are issued.
- IDLE:
  - start=1 and abort=0 at edge E0: latch a_mat, b_mat, rd_base; idx=0; clear mm_ovf; go to RUN.
  - Otherwise remain in IDLE.
- RUN:
  - Combinationally compute element idx in row-major order: idx 0=c00, 1=c01, 2=c10, 3=c11.
  - c_ij = a_i0*b_0j + a_i1*b_1j, computed unsigned at full 2*DATA_W+1 width.
  - Each edge registers wr_en=1, wr_addr=base_q+idx (mod 2^REG_AW), wr_data = low DATA_W bits of the sum, and mm_ovf |= (sum > 2^DATA_W-1). idx then increments.
  - At the edge where idx=3 (E4), go to DONE.
- DONE:
  - The registered write of c11 is visible; done=1.
  - Next edge: state=IDLE, wr_en=0.
- Timing:
  - Writes are visible in cycles 2..5 relative to the start cycle (cycle 0). Cycle 1 has wr_en=0.
  - wr_en is registered and is 1 only in the cycles that present a valid element.
- stall (combinational) = (state==IDLE & start & ~abort) | state==RUN | state==DONE. It is high for exactly 6 cycles (cycle 0 through cycle 5).
- done (combinational) = state==DONE.
- start while in RUN or DONE is ignored. The pipeline is stalled, so the same instruction keeps start high; it is not re-accepted, because the pipeline advances on the edge leaving DONE.
- abort:
  - In RUN or DONE: next edge state=IDLE, wr_en=0, done=0. Writes already committed stand.
  - abort and start together in IDLE: abort wins and nothing is latched.
- Input changes on a_mat/b_mat/rd_base after E0 have no effect.

Test Plan:
- Basic: A=0x04030201 ([1 2;3 4]), B=0x08070605 ([5 6;7 8]), rd_base=2, start pulse. Required: writes (2,0x13), (3,0x16), (4,0x2B), (5,0x32) in cycles 2..5; done=1 in cycle 5; mm_ovf=0; stall high cycles 0..5, low in cycle 6.
- Address wrap: same operands, rd_base=6. Required: write addresses 6, 7, 0, 1 with the same data.
- Overflow: A=0x10101010, B=0x10101010. Required: every element sum = 512, so four writes of 0x00 and mm_ovf=1 during done.
- Operand hold: change a_mat to 0xFFFFFFFF in cycle 1 of the basic test, and keep start high throughout. Required: identical results, exactly one operation, no re-start after done.
- Abort: assert abort in cycle 3 of the basic test. Required: only elements 0x13 and 0x16 are written; state IDLE in cycle 4; wr_en=0; done never asserted; stall low from cycle 4.
- Reset: assert reset asynchronously mid-cycle during cycle 3. Required: wr_en, stall, done and mm_ovf drop immediately; no further writes; a fresh start after reset release produces the full basic result.

Source files
------------

// File: rtl/matrix_mult_sequencer_if.sv
// Pipeline <-> matrix-multiply sequencer bundle: issue handshake, operands,
// stall/done status and the register-file write port override.
interface matrix_mult_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
);
    logic                  start;
    logic                  abort;
    logic [4*DATA_W-1:0]   a_mat;
    logic [4*DATA_W-1:0]   b_mat;
    logic [REG_AW-1:0]     rd_base;
    logic                  stall;
    logic                  wr_en;
    logic [REG_AW-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  done;
    logic                  mm_ovf;

    // Pipeline side: issues the instruction and consumes stall/write port.
    modport master (
        output start, abort, a_mat, b_mat, rd_base,
        input  stall, wr_en, wr_addr, wr_data, done, mm_ovf
    );

    // Sequencer side.
    modport slave (
        input  start, abort, a_mat, b_mat, rd_base,
        output stall, wr_en, wr_addr, wr_data, done, mm_ovf
    );
endinterface

// File: rtl/matrix_mult_sequencer.sv
// Execute-stage 2x2 matrix multiplier. Latches A, B and the destination base
// on acceptance, then emits one element of C = A x B per cycle (row-major)
// into the register-file write port while holding the pipeline stalled.
module matrix_mult_sequencer #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    matrix_mult_sequencer_if.slave  bus
);
    localparam int SUM_W = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [4*DATA_W-1:0] a_q, a_d;
    logic [4*DATA_W-1:0] b_q, b_d;
    logic [REG_AW-1:0]   base_q, base_d;
    logic                wr_en_q, wr_en_d;
    logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                mm_ovf_q, mm_ovf_d;

    logic [SUM_W-1:0]    elem_sum [4];
    logic [SUM_W-1:0]    cur_sum;
    logic                cur_ovf;

    // One dot-product per output element from the latched operands; the
    // sequencer just selects which one to commit each cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_elem
            localparam int RI = gi / 2;
            localparam int CJ = gi % 2;
            logic [DATA_W-1:0] a_i0, a_i1, b_0j, b_1j;
            assign a_i0 = a_q[(2*RI)*DATA_W   +: DATA_W];
            assign a_i1 = a_q[(2*RI+1)*DATA_W +: DATA_W];
            assign b_0j = b_q[CJ*DATA_W       +: DATA_W];
            assign b_1j = b_q[(2+CJ)*DATA_W   +: DATA_W];
            assign elem_sum[gi] = SUM_W'(a_i0) * SUM_W'(b_0j)
                                + SUM_W'(a_i1) * SUM_W'(b_1j);
        end
    endgenerate

    assign cur_sum = elem_sum[idx_q];
    assign cur_ovf = |cur_sum[SUM_W-1:DATA_W];

    // State and datapath registers; reset drops any operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            base_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            mm_ovf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            base_q    <= base_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            mm_ovf_q  <= mm_ovf_d;
        end
    end

    // Next-state: accept in IDLE, commit one element per RUN cycle, abort wins.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        base_d    = base_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mm_ovf_d  = mm_ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    a_d      = bus.a_mat;
                    b_d      = bus.b_mat;
                    base_d   = bus.rd_base;
                    idx_d    = '0;
                    mm_ovf_d = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + REG_AW'(idx_q);
                    wr_data_d = cur_sum[DATA_W-1:0];
                    mm_ovf_d  = mm_ovf_q | cur_ovf;
                    idx_d     = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: stall covers the accepting cycle through the final write.
    always_comb begin
        bus.stall   = ((state_q == IDLE) && bus.start && !bus.abort)
                    || (state_q == RUN) || (state_q == DONE);
        bus.done    = (state_q == DONE);
        bus.wr_en   = wr_en_q;
        bus.wr_addr = wr_addr_q;
        bus.wr_data = wr_data_q;
        bus.mm_ovf  = mm_ovf_q;
    end
endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Bench for matrix_mult_sequencer: directed scenarios plus randomized
// operations compared against a plain-arithmetic matrix product model.
module tb_matrix_mult_sequencer;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NC = 8;
    localparam int NO_ABORT = 99;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matrix_mult_sequencer_if #(.DATA_W(DW), .REG_AW(AW)) bus_if ();

    matrix_mult_sequencer #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Per-cycle observations (cycle 0 = start cycle) and model expectations.
    logic [2:0]    obs_ctl [NC];   // {stall, wr_en, done}
    logic [AW-1:0] obs_addr[NC];
    logic [DW-1:0] obs_data[NC];
    logic          obs_ovf [NC];
    logic [2:0]    exp_ctl [NC];
    logic [AW-1:0] exp_addr[NC];
    logic [DW-1:0] exp_data[NC];
    logic          exp_ovf;

    // Reference: C = A x B with ordinary integers, then derive the cycle
    // timeline (writes cycles 2..5, done cycle 5) truncated by abort.
    task automatic build_expect(input logic [31:0] a, input logic [31:0] b,
                                input logic [AW-1:0] base, input int ac);
        int am[2][2];
        int bm[2][2];
        int cm[4];
        int last;
        bit acc;
        bit st, we, dn;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                am[i][j] = int'((a >> (8 * (2 * i + j))) & 32'hFF);
                bm[i][j] = int'((b >> (8 * (2 * i + j))) & 32'hFF);
            end
        exp_ovf = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                cm[2 * i + j] = am[i][0] * bm[0][j] + am[i][1] * bm[1][j];
                if (cm[2 * i + j] > 255) exp_ovf = 1'b1;
            end
        acc  = (ac != 0);
        last = (ac < 5) ? ac : 5;
        for (int c = 0; c < NC; c++) begin
            st = acc && (c <= last);
            we = acc && (c >= 2) && (c <= last);
            dn = acc && (c == 5) && (last == 5);
            exp_ctl[c]  = {st, we, dn};
            exp_addr[c] = '0;
            exp_data[c] = '0;
            if (we) begin
                exp_addr[c] = AW'(int'(base) + c - 2);
                exp_data[c] = DW'(cm[c - 2] % 256);
            end
        end
    endtask

    // Drive one instruction and record ncyc cycles of outputs. After cycle 0
    // the operand inputs are scrambled; they must not influence the result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [AW-1:0] base, input int ac,
                          input bit hold, input bit a_ones, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            bus_if.start = (c == 0) || (hold && c <= 5);
            bus_if.abort = (c == ac);
            if (c == 0) begin
                bus_if.a_mat   = a;
                bus_if.b_mat   = b;
                bus_if.rd_base = base;
            end else begin
                bus_if.a_mat   = (a_ones && c == 1) ? 32'hFFFF_FFFF : $urandom;
                bus_if.b_mat   = $urandom;
                bus_if.rd_base = AW'($urandom);
            end
            @(negedge clk);
            obs_ctl[c]  = {bus_if.stall, bus_if.wr_en, bus_if.done};
            obs_addr[c] = bus_if.wr_addr;
            obs_data[c] = bus_if.wr_data;
            obs_ovf[c]  = bus_if.mm_ovf;
            if (bus_if.wr_en)
                $display("[%0t] cycle %0d write r%0d <= 0x%02h%s", $time, c,
                         bus_if.wr_addr, bus_if.wr_data, bus_if.done ? " (done)" : "");
        end
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({bus_if.stall, bus_if.wr_en, bus_if.done, bus_if.mm_ovf,
             bus_if.wr_addr, bus_if.wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_state: got stall=%b wr_en=%b done=%b ovf=%b addr=%0d data=0x%02h, expected all zero",
                     bus_if.stall, bus_if.wr_en, bus_if.done, bus_if.mm_ovf,
                     bus_if.wr_addr, bus_if.wr_data);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_if.stall, bus_if.wr_en, bus_if.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got stall/wr_en/done=%b expected 000",
                     {bus_if.stall, bus_if.wr_en, bus_if.done});
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] want_d[4];
        want_d = '{8'h13, 8'h16, 8'h2B, 8'h32};
        build_expect(32'h0403_0201, 32'h0807_0605, 3'd2, NO_ABORT);
        run_op(32'h0403_0201, 32'h0807_0605, 3'd2, NO_ABORT, 1'b0, 1'b0, NC);
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (obs_ctl[c] !== exp_ctl[c]) begin
                errors++;
                $display("FAIL basic_ctl cycle %0d: stall/wr_en/done got %b expected %b", c, obs_ctl[c], exp_ctl[c]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_addr[k + 2] !== AW'(k + 2) || obs_data[k + 2] !== want_d[k]) begin
                errors++;
                $display("FAIL basic_write %0d: got r%0d=0x%02h expected r%0d=0x%02h",
                         k, obs_addr[k + 2], obs_data[k + 2], k + 2, want_d[k]);
            end
        end
        checks++;
        if (obs_ovf[5] !== 1'b0) begin
            errors++;
            $display("FAIL basic_ovf: got %b expected 0", obs_ovf[5]);
        end
    endtask

    task automatic test_wrap();
        build_expect(32'h0403_0201, 32'h0807_0605, 3'd6, NO_ABORT);
        run_op(32'h0403_0201, 32'h0807_0605, 3'd6, NO_ABORT, 1'b0, 1'b0, NC);
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (obs_ctl[c] !== exp_ctl[c]) begin
                errors++;
                $display("FAIL wrap_ctl cycle %0d: got %b expected %b", c, obs_ctl[c], exp_ctl[c]);
            end
            if (exp_ctl[c][1]) begin
                checks++;
                if (obs_addr[c] !== exp_addr[c] || obs_data[c] !== exp_data[c]) begin
                    errors++;
                    $display("FAIL wrap_write cycle %0d: got r%0d=0x%02h expected r%0d=0x%02h",
                             c, obs_addr[c], obs_data[c], exp_addr[c], exp_data[c]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        build_expect(32'h1010_1010, 32'h1010_1010, 3'd0, NO_ABORT);
        run_op(32'h1010_1010, 32'h1010_1010, 3'd0, NO_ABORT, 1'b0, 1'b0, NC);
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (obs_ctl[c] !== exp_ctl[c]) begin
                errors++;
                $display("FAIL ovf_ctl cycle %0d: got %b expected %b", c, obs_ctl[c], exp_ctl[c]);
            end
            if (exp_ctl[c][1]) begin
                checks++;
                if (obs_addr[c] !== exp_addr[c] || obs_data[c] !== 8'h00) begin
                    errors++;
                    $display("FAIL ovf_write cycle %0d: got r%0d=0x%02h expected r%0d=0x00",
                             c, obs_addr[c], obs_data[c], exp_addr[c]);
                end
            end
        end
        checks++;
        if (obs_ovf[5] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b expected 1", obs_ovf[5]);
        end
    endtask

    task automatic test_hold();
        build_expect(32'h0403_0201, 32'h0807_0605, 3'd2, NO_ABORT);
        run_op(32'h0403_0201, 32'h0807_0605, 3'd2, NO_ABORT, 1'b1, 1'b1, NC);
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (obs_ctl[c] !== exp_ctl[c]) begin
                errors++;
                $display("FAIL hold_ctl cycle %0d: got %b expected %b", c, obs_ctl[c], exp_ctl[c]);
            end
            if (exp_ctl[c][1]) begin
                checks++;
                if (obs_addr[c] !== exp_addr[c] || obs_data[c] !== exp_data[c]) begin
                    errors++;
                    $display("FAIL hold_write cycle %0d: got r%0d=0x%02h expected r%0d=0x%02h",
                             c, obs_addr[c], obs_data[c], exp_addr[c], exp_data[c]);
                end
            end
        end
    endtask

    task automatic test_abort();
        build_expect(32'h0403_0201, 32'h0807_0605, 3'd2, 3);
        run_op(32'h0403_0201, 32'h0807_0605, 3'd2, 3, 1'b0, 1'b0, NC);
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (obs_ctl[c] !== exp_ctl[c]) begin
                errors++;
                $display("FAIL abort_ctl cycle %0d: got %b expected %b", c, obs_ctl[c], exp_ctl[c]);
            end
            if (exp_ctl[c][1]) begin
                checks++;
                if (obs_addr[c] !== exp_addr[c] || obs_data[c] !== exp_data[c]) begin
                    errors++;
                    $display("FAIL abort_write cycle %0d: got r%0d=0x%02h expected r%0d=0x%02h",
                             c, obs_addr[c], obs_data[c], exp_addr[c], exp_data[c]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        // Overflowing operands so mm_ovf is already set when reset hits.
        run_op(32'h1010_1010, 32'h1010_1010, 3'd1, NO_ABORT, 1'b0, 1'b0, 3);
        @(posedge clk);
        #2;
        checks++;
        if ({bus_if.wr_en, bus_if.stall, bus_if.mm_ovf} !== 3'b111) begin
            errors++;
            $display("FAIL areset_pre: wr_en/stall/ovf got %b expected 111",
                     {bus_if.wr_en, bus_if.stall, bus_if.mm_ovf});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_if.wr_en, bus_if.stall, bus_if.done, bus_if.mm_ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL areset_drop: wr_en/stall/done/ovf got %b expected 0000",
                     {bus_if.wr_en, bus_if.stall, bus_if.done, bus_if.mm_ovf});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({bus_if.wr_en, bus_if.stall, bus_if.done} !== 3'b000) begin
                errors++;
                $display("FAIL areset_quiet cycle %0d: wr_en/stall/done got %b expected 000",
                         c, {bus_if.wr_en, bus_if.stall, bus_if.done});
            end
        end
        build_expect(32'h0403_0201, 32'h0807_0605, 3'd2, NO_ABORT);
        run_op(32'h0403_0201, 32'h0807_0605, 3'd2, NO_ABORT, 1'b0, 1'b0, NC);
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (obs_ctl[c] !== exp_ctl[c]) begin
                errors++;
                $display("FAIL areset_rerun_ctl cycle %0d: got %b expected %b", c, obs_ctl[c], exp_ctl[c]);
            end
            if (exp_ctl[c][1]) begin
                checks++;
                if (obs_addr[c] !== exp_addr[c] || obs_data[c] !== exp_data[c]) begin
                    errors++;
                    $display("FAIL areset_rerun_write cycle %0d: got r%0d=0x%02h expected r%0d=0x%02h",
                             c, obs_addr[c], obs_data[c], exp_addr[c], exp_data[c]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0]   a, b, mask;
        logic [AW-1:0] base;
        int            ac;
        bit            hold;
        for (int n = 0; n < 30; n++) begin
            mask = ($urandom_range(0, 1) == 0) ? 32'h0F0F_0F0F : 32'hFFFF_FFFF;
            a    = $urandom & mask;
            b    = $urandom & mask;
            base = AW'($urandom);
            ac   = $urandom_range(0, 9);
            if (ac > 7) ac = NO_ABORT;
            hold = (ac == NO_ABORT) ? 1'($urandom_range(0, 1)) : 1'b0;
            build_expect(a, b, base, ac);
            run_op(a, b, base, ac, hold, 1'b0, NC);
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (obs_ctl[c] !== exp_ctl[c]) begin
                    errors++;
                    $display("FAIL rand%0d_ctl cycle %0d: got %b expected %b (abort@%0d)",
                             n, c, obs_ctl[c], exp_ctl[c], ac);
                end
                if (exp_ctl[c][1]) begin
                    checks++;
                    if (obs_addr[c] !== exp_addr[c] || obs_data[c] !== exp_data[c]) begin
                        errors++;
                        $display("FAIL rand%0d_write cycle %0d: got r%0d=0x%02h expected r%0d=0x%02h",
                                 n, c, obs_addr[c], obs_data[c], exp_addr[c], exp_data[c]);
                    end
                end
            end
            if (exp_ctl[5][0]) begin
                checks++;
                if (obs_ovf[5] !== exp_ovf) begin
                    errors++;
                    $display("FAIL rand%0d_ovf: got %b expected %b", n, obs_ovf[5], exp_ovf);
                end
            end
        end
    endtask

    initial begin
        bus_if.start   = 1'b0;
        bus_if.abort   = 1'b0;
        bus_if.a_mat   = '0;
        bus_if.b_mat   = '0;
        bus_if.rd_base = '0;
        reset          = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_hold();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
